// File: rtl/sound_engine_if.sv
// sound_engine_if: groups the game-side event/mute inputs and the speaker/status
// outputs of sound_engine into one bundle.
//   ev        : N_EV one-cycle event pulses (bit N_EV-1 = highest priority)
//   mute      : silences the speaker line without touching tone timing
//   sound     : registered square-wave speaker drive
//   busy      : high while a tone plays
//   active_id : index of the playing event, 0 when idle
//   dbg_state : FSM state for observation (0 = IDLE, 1 = TONE)
// Handshake: ev is fire-and-forget; a set bit in the cycle before an edge is a
// trigger at that edge; there is no ready/back-pressure, rejected pulses are lost.
// Modports: master = game logic side, slave = sound engine side.
interface sound_engine_if #(
   parameter int N_EV = 3,
   parameter int IDW  = (N_EV > 1) ? $clog2(N_EV) : 1
);
   logic [N_EV-1:0] ev;
   logic            mute;
   logic            sound;
   logic            busy;
   logic [IDW-1:0]  active_id;
   logic            dbg_state;

   modport master (
      output ev, mute,
      input  sound, busy, active_id, dbg_state
   );

   modport slave (
      input  ev, mute,
      output sound, busy, active_id, dbg_state
   );
endinterface

// File: rtl/sound_engine.sv
// sound_engine: prioritised, preemptive square-wave tone generator for game events.
// Each event i plays a tone of half-period HALF_PERIODS[i] for DURATIONS[i] cycles;
// events flagged in TWO_NOTE drop an octave (double half-period) halfway through.
// Ports:
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : sound_engine_if.slave (ev, mute in; sound, busy, active_id, dbg_state out)
module sound_engine #(
   parameter int                       N_EV         = 3,
   parameter int                       HP_W         = 16,
   parameter int                       DUR_W        = 24,
   parameter logic [N_EV*HP_W-1:0]     HALF_PERIODS = {16'd8, 16'd5, 16'd3},
   parameter logic [N_EV*DUR_W-1:0]    DURATIONS    = {24'd40, 24'd30, 24'd20},
   parameter logic [N_EV-1:0]          TWO_NOTE     = 3'b100
) (
   input  logic          clk,
   input  logic          rst,
   sound_engine_if.slave bus
);
   localparam int IDW = (N_EV > 1) ? $clog2(N_EV) : 1;
   localparam int HPX = HP_W + 1;

   typedef enum logic [0:0] {IDLE = 1'b0, TONE = 1'b1} state_t;

   state_t           state;
   logic [IDW-1:0]   active_id;
   logic             busy;
   logic             phase;
   logic             note;       // 0 = first note, 1 = second (lower) note
   logic             sound;
   logic [HPX-1:0]   hp_cnt;
   logic [DUR_W-1:0] dur_cnt;

   // Arbitration: highest set ev bit wins.
   logic [IDW-1:0]   win_id;
   logic             any_ev;
   always_comb begin
      win_id = '0;
      for (int i = 0; i < N_EV; i++) begin
         if (bus.ev[i]) win_id = IDW'(i);
      end
      any_ev = |bus.ev;
   end

   // Lower-priority events than the playing one are dropped; equal retriggers.
   logic accept;
   assign accept = any_ev && ((state == IDLE) || (win_id >= active_id));

   // Per-event constants of the playing tone.
   logic [HP_W-1:0]  hp_base;
   logic [DUR_W-1:0] dur_sel;
   logic             two_sel;
   always_comb begin
      hp_base = HALF_PERIODS[HP_W-1:0];
      dur_sel = DURATIONS[DUR_W-1:0];
      two_sel = TWO_NOTE[0];
      for (int i = 0; i < N_EV; i++) begin
         if (active_id == IDW'(i)) begin
            hp_base = HALF_PERIODS[i*HP_W +: HP_W];
            dur_sel = DURATIONS[i*DUR_W +: DUR_W];
            two_sel = TWO_NOTE[i];
         end
      end
   end

   // Second note doubles the half-period; the extra bit keeps it overflow-free.
   logic [HPX-1:0]   hp_last;
   logic [DUR_W-1:0] dur_last;
   logic [DUR_W-1:0] half_last;
   assign hp_last   = (note ? {hp_base, 1'b0} : {1'b0, hp_base}) - HPX'(1);
   assign dur_last  = dur_sel - DUR_W'(1);
   assign half_last = (dur_sel >> 1) - DUR_W'(1);

   // sound is registered from the next-state phase so it lines up with busy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         active_id <= '0;
         busy      <= 1'b0;
         phase     <= 1'b0;
         note      <= 1'b0;
         sound     <= 1'b0;
         hp_cnt    <= '0;
         dur_cnt   <= '0;
      end else if (accept) begin
         // Start or restart; a trigger also wins over a same-cycle tone end.
         state     <= TONE;
         active_id <= win_id;
         busy      <= 1'b1;
         phase     <= 1'b1;
         note      <= 1'b0;
         sound     <= ~bus.mute;
         hp_cnt    <= '0;
         dur_cnt   <= '0;
      end else begin
         case (state)
            TONE: begin
               if (dur_cnt == dur_last) begin
                  state     <= IDLE;
                  active_id <= '0;
                  busy      <= 1'b0;
                  phase     <= 1'b0;
                  note      <= 1'b0;
                  sound     <= 1'b0;
                  hp_cnt    <= '0;
                  dur_cnt   <= '0;
               end else begin
                  dur_cnt <= dur_cnt + DUR_W'(1);
                  if (two_sel && !note && (dur_cnt == half_last)) begin
                     // Next cycle is dur_cnt == DUR/2: second note starts high.
                     note   <= 1'b1;
                     phase  <= 1'b1;
                     sound  <= ~bus.mute;
                     hp_cnt <= '0;
                  end else if (hp_cnt == hp_last) begin
                     phase  <= ~phase;
                     sound  <= ~phase & ~bus.mute;
                     hp_cnt <= '0;
                  end else begin
                     sound  <= phase & ~bus.mute;
                     hp_cnt <= hp_cnt + HPX'(1);
                  end
               end
            end
            default: begin
               sound <= 1'b0;
            end
         endcase
      end
   end

   assign bus.sound     = sound;
   assign bus.busy      = busy;
   assign bus.active_id = active_id;
   assign bus.dbg_state = (state == TONE);
endmodule

// File: tb/tb_sound_engine.sv
// tb_sound_engine: directed self-checking bench for sound_engine with the default
// parameters (half-periods 3/5/8, durations 20/30/40, event 2 two-note).
// Inputs change and outputs are sampled on the falling clock edge.
// "t" below is the tone-relative cycle: t=0 is the cycle after the trigger edge.
module tb_sound_engine;
   logic clk;
   logic rst_n;

   sound_engine_if #(.N_EV(3)) bus ();

   sound_engine dut (
      .clk (clk),
      .rst (rst_n),
      .bus (bus)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- checking ----------------
   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference tone shape from the event table, independent of counters.
   function automatic logic exp_snd(input int id, input int t);
      int hp;
      hp = (id == 0) ? 3 : (id == 1) ? 5 : 8;
      if (id == 2 && t >= 20) return (((t - 20) / 16) % 2) == 0;
      return ((t / hp) % 2) == 0;
   endfunction

   // ---------------- driver tasks ----------------
   // Pulse ev for exactly one sampling edge; returns at the following negedge (t=0).
   task automatic pulse(input logic [2:0] v);
      bus.ev = v;
      @(negedge clk);
      bus.ev = 3'b000;
   endtask

   task automatic check_now(input int id, input int t, input bit muted);
      check_val($sformatf("busy id%0d t%0d", id, t), 32'(bus.busy), 32'd1);
      check_val($sformatf("active_id id%0d t%0d", id, t), 32'(bus.active_id), 32'(id));
      check_val($sformatf("sound id%0d t%0d", id, t), 32'(bus.sound),
                32'(exp_snd(id, t) && !muted));
   endtask

   task automatic check_tone(input int id, input int t0, input int n, input bit muted);
      for (int c = 0; c < n; c++) begin
         check_now(id, t0 + c, muted);
         @(negedge clk);
      end
   endtask

   task automatic check_idle(input string tag, input int n);
      for (int c = 0; c < n; c++) begin
         check_val($sformatf("%s idle sound c%0d", tag, c), 32'(bus.sound), 32'd0);
         check_val($sformatf("%s idle busy c%0d", tag, c), 32'(bus.busy), 32'd0);
         check_val($sformatf("%s idle id c%0d", tag, c), 32'(bus.active_id), 32'd0);
         @(negedge clk);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n    = 1'b0;
      bus.ev   = 3'b000;
      bus.mute = 1'b0;
      repeat (2) @(negedge clk);
      check_idle("reset", 1);
      rst_n = 1'b1;
      check_idle("post_reset", 2);

      // Lowest event alone: 3 high / 3 low for 20 cycles.
      pulse(3'b001);
      check_tone(0, 0, 20, 1'b0);
      check_idle("ev0_end", 3);

      // Preemption by event 2 at edge k+5.
      pulse(3'b001);
      check_tone(0, 0, 4, 1'b0);
      check_now(0, 4, 1'b0);
      pulse(3'b100);
      check_tone(2, 0, 40, 1'b0);
      check_idle("preempt_end", 3);

      // Lower-priority pulse during event 2 is ignored; two-note shape checked.
      pulse(3'b100);
      check_tone(2, 0, 10, 1'b0);
      check_now(2, 10, 1'b0);
      pulse(3'b001);
      check_tone(2, 11, 29, 1'b0);
      check_idle("ignore_end", 3);

      // Simultaneous events pick 1; retrigger at edge k+25 gives 55 busy cycles.
      pulse(3'b011);
      check_tone(1, 0, 24, 1'b0);
      check_now(1, 24, 1'b0);
      pulse(3'b010);
      check_tone(1, 0, 30, 1'b0);
      check_idle("retrig_end", 3);

      // Retrigger on the last tone cycle: no idle gap.
      pulse(3'b001);
      check_tone(0, 0, 19, 1'b0);
      check_now(0, 19, 1'b0);
      pulse(3'b001);
      check_tone(0, 0, 20, 1'b0);
      check_idle("edge_retrig_end", 2);

      // Asynchronous reset mid-tone while sound is high.
      pulse(3'b010);
      check_tone(1, 0, 3, 1'b0);
      check_now(1, 3, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check_val("async_rst sound", 32'(bus.sound), 32'd0);
      check_val("async_rst busy", 32'(bus.busy), 32'd0);
      check_val("async_rst id", 32'(bus.active_id), 32'd0);
      check_val("async_rst state", 32'(bus.dbg_state), 32'd0);
      @(negedge clk);
      check_idle("rst_hold", 1);
      rst_n = 1'b1;
      check_idle("rst_release", 5);

      // Mute during event 1, released at t=12 (takes effect from t=13).
      bus.mute = 1'b1;
      pulse(3'b010);
      check_tone(1, 0, 12, 1'b1);
      check_now(1, 12, 1'b1);
      bus.mute = 1'b0;
      @(negedge clk);
      check_tone(1, 13, 17, 1'b0);
      check_idle("mute_end", 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/sound_engine.md
Name: sound_engine

Overview:
- Parametrised successor to the game's single-tone sound output.
- Accepts N_EV one-cycle event pulses (hit, wall, goal, ...) from game logic. Plays a per-event square-wave tone of per-event pitch and duration on a 1-bit speaker line.
- Adds fixed priority with preemption, an optional two-note (falling) mode per event, a mute input, and busy/active-id status.
- Sits between game FSM and the speaker/PWM pin.

Parameters:
- N_EV, 3, number of event inputs; index N_EV-1 has highest priority.
- HP_W, 16, width of half-period values in clk cycles.
- DUR_W, 24, width of duration values in clk cycles.
- HALF_PERIODS, {16'd8,16'd5,16'd3}, packed N_EV*HP_W. Field i is the half-period of event i; legal range ≥1.
- DURATIONS, {24'd40,24'd30,24'd20}, packed N_EV*DUR_W. Field i is the tone length of event i in cycles; legal range ≥2.
- TWO_NOTE, 3'b100, N_EV-bit mask. Bit i set: event i plays its second half at double half-period.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- ev  input  N_EV  event pulses; a bit high for a cycle is a trigger.
- mute  input  1  forces sound low; timing unaffected.
- sound  output  1  square-wave speaker drive.
- busy  output  1  high while a tone plays.
- active_id  output  clog2(N_EV) (min 1)  index of playing event; 0 when idle.

Behaviour:
- Reset (rst=0, async): state IDLE, sound=0, busy=0, active_id=0, all counters 0. Holds while rst=0; release is synchronous to next clk edge.
- Arbitration each edge: winner = highest set bit of ev.
- States:
  - IDLE -> TONE on any ev bit.
  - TONE -> TONE (restart) when winner index ≥ active_id. Equal index retriggers, restarting duration.
  - ev bits with index < active_id are ignored and not queued.
  - TONE -> IDLE when duration counter reaches DUR-1 with no accepted trigger that cycle.
- Start/restart, trigger sampled at edge k; from cycle k+1:
  - busy=1, active_id=winner, internal phase=1, half-period counter=0, duration counter=0, note=first.
- Tone generation in TONE:
  - hp_cnt increments each cycle.
  - When hp_cnt==HP_cur-1: phase toggles and hp_cnt clears.
  - HP_cur = HALF_PERIODS[id]. In second note, HP_cur = 2*HALF_PERIODS[id], computed at HP_W+1 bits with no overflow.
- Two-note: if TWO_NOTE[id], the second note begins when dur_cnt reaches floor(DUR/2). At that point phase=1 and hp_cnt=0.
- End: on the cycle after dur_cnt==DUR-1, state=IDLE, busy=0, active_id=0, phase=0. Total busy time is exactly DUR cycles.
- sound = phase & busy & ~mute, registered. mute has no effect on state or counters.
- Simultaneous end and new trigger: trigger wins; new tone starts with no idle gap.
- Width rules:
  - Counters are unsigned: hp_cnt HP_W+1 bits, dur_cnt DUR_W bits, no wrap in legal range.
  - Half-period 0 or duration <2 is illegal; behaviour undefined, not verified.

Test Plan:
- Reset, ev=3'b001 for one cycle at edge k -> from k+1: sound high 3, low 3, repeating. busy=1 and active_id=0 for exactly 20 cycles. sound=0, busy=0 thereafter.
- ev[0] at k, ev[2] at k+5 -> at k+6 active_id=2, sound restarts high for 8 cycles. busy stays high continuously and falls at k+46.
- ev[2] playing, pulse ev[0] at 10 cycles in -> ignored: active_id stays 2, tone pattern unchanged, busy ends 40 cycles after ev[2] start.
- ev[2] alone (TWO_NOTE bit2 set) -> cycles 0-19 half-period 8, cycles 20-39 half-period 16 (phase high at cycle 20). Busy 40 cycles.
- ev=3'b011 in one cycle -> active_id=1, half-period 5, duration 30. Also ev[1] retriggered at cycle 25 -> duration restarts, busy totals 55 cycles.
- rst driven low mid-tone between clock edges -> sound, busy, active_id 0 immediately, without waiting for a clk edge. After release, idle until next ev.
- mute=1 during ev[1] tone -> sound=0 throughout, busy still 30 cycles. mute released mid-tone -> waveform resumes in correct phase.
